gin_xbus: RTL and testbench

- Receiving end of one GIN row bus. It takes the controller's valid/ready/data/tag transfer and multicasts it to the PEs of that row whose scanned-in XID matches the tag.
- Holds the transfer in a one-entry buffer and tracks per-PE acceptance, so PEs may accept in different cycles.
- It is the responder paired with the controller's GLB_*_valid / GLB_*_ready, tag_X and PE_data_in outputs.
- One instance per row per data type (ifmap/filter/ipsum); a Y-level instance of the same block selects rows.

---
 rtl/gin_xbus.sv | 150 +++++++++++++++
 tb/tb_gin_xbus.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_xbus.sv
// rtl/gin_xbus.sv - GIN row-bus receiver: tag-matched multicast of one buffered word to PE slaves

`ifndef NUMS_PE_COL
`define NUMS_PE_COL 8
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module gin_xbus #(
    parameter int NUMS_SLAVE = `NUMS_PE_COL,
    parameter int ID_SIZE    = `XID_BITS,
    parameter int DATA_SIZE  = `DATA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_id,
    input  logic [ID_SIZE-1:0]    id_scan_in,
    output logic [ID_SIZE-1:0]    id_scan_out,
    input  logic [ID_SIZE-1:0]    tag,
    input  logic                  master_valid,
    output logic                  master_ready,
    input  logic [DATA_SIZE-1:0]  master_data,
    output logic [NUMS_SLAVE-1:0] slave_valid,
    input  logic [NUMS_SLAVE-1:0] slave_ready,
    output logic [DATA_SIZE-1:0]  slave_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ID_SIZE-1:0]    id [NUMS_SLAVE];
    logic [NUMS_SLAVE-1:0] match;
    logic [NUMS_SLAVE-1:0] pending;
    logic [NUMS_SLAVE-1:0] remain;
    logic [DATA_SIZE-1:0]  data_q;
    logic [ID_SIZE-1:0]    tag_q;
    logic                  accept;

    // ID scan chain: slot 0 takes the scan input, every other slot takes its lower neighbour
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUMS_SLAVE; i++) begin
                id[i] <= '0;
            end
        end else if (set_id) begin
            id[0] <= id_scan_in;
            for (int i = 1; i < NUMS_SLAVE; i++) begin
                id[i] <= id[i-1];
            end
        end
    end

    assign id_scan_out = id[NUMS_SLAVE-1];

    // Per-slot tag match on the full ID width; duplicates simply multicast
    always_comb begin
        match = '0;
        for (int i = 0; i < NUMS_SLAVE; i++) begin
            match[i] = (id[i] == tag);
        end
    end

    assign accept = master_valid && master_ready;

    // Slots still owed the word after this cycle's acceptances
    assign remain = pending & ~slave_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a word with no matching slot is swallowed without leaving IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (match != '0)) begin
                    state_next = BCAST;
                end
            end
            BCAST: begin
                if (remain == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ready depends only on state, scan enable and reset, never on master_valid
    always_comb begin
        master_ready = 1'b0;
        slave_valid  = '0;
        case (state)
            IDLE:    master_ready = !set_id && rst;
            BCAST:   slave_valid  = pending;
            default: begin
                master_ready = 1'b0;
                slave_valid  = '0;
            end
        endcase
    end

    // One-entry word buffer and per-slot delivery mask
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            tag_q   <= '0;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q  <= master_data;
                        tag_q   <= tag;
                        pending <= match;
                    end
                end
                BCAST: begin
                    pending <= remain;
                end
                default: pending <= '0;
            endcase
        end
    end

    // Shared payload holds its last value outside a broadcast; consumers qualify with slave_valid
    assign slave_data = data_q;

    // The latched word and tag must not move while a broadcast is in flight
    hold_during_bcast: assert property (
        @(posedge clk) disable iff (!rst)
        (state == BCAST) |=> ((state == IDLE) || ($stable(tag_q) && $stable(data_q)))
    );

endmodule

// File: tb/tb_gin_xbus.sv
// tb/tb_gin_xbus.sv - scoreboard bench for gin_xbus
module tb_gin_xbus;

    logic        clk;
    logic        rst;
    logic        set_id;
    logic [3:0]  id_scan_in;
    logic [3:0]  id_scan_out;
    logic [3:0]  tag;
    logic        master_valid;
    logic        master_ready;
    logic [31:0] master_data;
    logic [7:0]  slave_valid;
    logic [7:0]  slave_ready;
    logic [31:0] slave_data;

    gin_xbus #(
        .NUMS_SLAVE(8),
        .ID_SIZE   (4),
        .DATA_SIZE (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .set_id      (set_id),
        .id_scan_in  (id_scan_in),
        .id_scan_out (id_scan_out),
        .tag         (tag),
        .master_valid(master_valid),
        .master_ready(master_ready),
        .master_data (master_data),
        .slave_valid (slave_valid),
        .slave_ready (slave_ready),
        .slave_data  (slave_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  mask;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          delivered = 0;
    logic [3:0]  mid [8];
    exp_t        e;
    logic [7:0]  m;
    logic        exp_ready;
    logic [7:0]  exp_valid;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [3:0] v);
        set_id     = 1'b1;
        id_scan_in = v;
        step();
    endtask

    // Monitor: models IDs, predicts ready/valid, pushes expected words on accept, retires them on delivery
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            for (int i = 0; i < 8; i++) mid[i] = 4'd0;
        end else begin
            exp_ready = (sb.size() == 0) && !set_id;
            exp_valid = (sb.size() == 0) ? 8'h00 : sb[0].mask;
            chk("mon_master_ready", {63'd0, master_ready}, {63'd0, exp_ready});
            chk("mon_slave_valid", {56'd0, slave_valid}, {56'd0, exp_valid});
            if ((sb.size() != 0) && ((slave_valid & slave_ready) != 8'h00)) begin
                e = sb[0];
                chk("mon_slave_data", {32'd0, slave_data}, {32'd0, e.data});
                e.mask = e.mask & ~slave_ready;
                if (e.mask == 8'h00) begin
                    void'(sb.pop_front());
                    delivered++;
                end else begin
                    sb[0] = e;
                end
            end
            if (master_valid && exp_ready) begin
                for (int i = 0; i < 8; i++) m[i] = (mid[i] == tag);
                if (m != 8'h00) sb.push_back({m, master_data});
            end
            if (set_id) begin
                for (int i = 7; i > 0; i--) mid[i] = mid[i-1];
                mid[0] = id_scan_in;
            end
        end
    end

    logic [31:0] words [4];
    logic [3:0]  tags  [4];
    logic [7:0]  ev;
    int          idx;
    int          d0;
    logic        acc;

    initial begin
        rst          = 1'b0;
        set_id       = 1'b0;
        id_scan_in   = 4'd0;
        tag          = 4'd0;
        master_valid = 1'b0;
        master_data  = 32'd0;
        slave_ready  = 8'hFF;
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h33333333; words[3] = 32'h44444444;
        tags[0] = 4'd1; tags[1] = 4'd5; tags[2] = 4'd5; tags[3] = 4'd0;

        // reset state
        #12;
        chk("rst_master_ready", {63'd0, master_ready}, 64'd0);
        chk("rst_slave_valid", {56'd0, slave_valid}, 64'd0);
        chk("rst_slave_data", {32'd0, slave_data}, 64'd0);
        chk("rst_id_scan_out", {60'd0, id_scan_out}, 64'd0);
        step();
        rst = 1'b1;
        step();

        // scan 0..7, then 7..0 which pushes the first batch out of slot 7
        for (int v = 0; v < 8; v++) begin
            scan(4'(v));
            chk("scan1_out", {60'd0, id_scan_out}, 64'd0);
        end
        for (int j = 1; j <= 8; j++) begin
            scan(4'(8 - j));
            chk("scan2_out", {60'd0, id_scan_out}, (j < 8) ? 64'(j) : 64'd7);
        end
        set_id = 1'b0;
        step();
        step();
        chk("scan_hold", {60'd0, id_scan_out}, 64'd7);

        // unicast: id[i]=i, tag 3
        tag          = 4'd3;
        master_data  = 32'hA5A5A5A5;
        master_valid = 1'b1;
        step();
        master_valid = 1'b0;
        chk("uni_valid", {56'd0, slave_valid}, 64'h08);
        chk("uni_data", {32'd0, slave_data}, 64'hA5A5A5A5);
        chk("uni_ready_busy", {63'd0, master_ready}, 64'd0);
        step();
        chk("uni_valid_done", {56'd0, slave_valid}, 64'd0);
        chk("uni_ready_back", {63'd0, master_ready}, 64'd1);

        // staggered multicast: all IDs 2
        for (int v = 0; v < 8; v++) scan(4'd2);
        set_id       = 1'b0;
        slave_ready  = 8'h00;
        tag          = 4'd2;
        master_data  = 32'h12345678;
        master_valid = 1'b1;
        step();
        master_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ev = 8'hFF << k;
            chk("stag_valid", {56'd0, slave_valid}, {56'd0, ev});
            chk("stag_ready", {63'd0, master_ready}, 64'd0);
            slave_ready = 8'(1 << k);
            step();
        end
        chk("stag_valid_done", {56'd0, slave_valid}, 64'd0);
        chk("stag_ready_back", {63'd0, master_ready}, 64'd1);

        // no match: IDs back to 0..7 by slot, tag 9
        for (int v = 7; v >= 0; v--) scan(4'(v));
        set_id       = 1'b0;
        slave_ready  = 8'hFF;
        tag          = 4'd9;
        master_data  = 32'h0BADF00D;
        master_valid = 1'b1;
        step();
        master_valid = 1'b0;
        chk("nomatch_valid", {56'd0, slave_valid}, 64'd0);
        chk("nomatch_ready", {63'd0, master_ready}, 64'd1);
        step();

        // back-to-back with toggling backpressure
        d0           = delivered;
        idx          = 0;
        master_valid = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (idx == 4) break;
            master_data = words[idx];
            tag         = tags[idx];
            slave_ready = cyc[0] ? 8'hFF : 8'h00;
            acc         = master_ready;
            step();
            if (acc) idx++;
        end
        master_valid = 1'b0;
        chk("b2b_accepts", 64'(idx), 64'd4);
        slave_ready = 8'hFF;
        for (int w = 0; w < 20; w++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("b2b_drained", 64'(sb.size()), 64'd0);
        chk("b2b_delivered", 64'(delivered - d0), 64'd4);
        step();

        // reset mid-broadcast with pending = 0F
        for (int v = 0; v < 4; v++) scan(4'd1);
        for (int v = 0; v < 4; v++) scan(4'd6);
        set_id       = 1'b0;
        slave_ready  = 8'h00;
        tag          = 4'd6;
        master_data  = 32'hDEADBEEF;
        master_valid = 1'b1;
        step();
        master_valid = 1'b0;
        chk("rmid_valid", {56'd0, slave_valid}, 64'h0F);
        #2;
        rst = 1'b0;
        #1;
        chk("rmid_valid_async", {56'd0, slave_valid}, 64'd0);
        chk("rmid_ready_async", {63'd0, master_ready}, 64'd0);
        chk("rmid_scan_out", {60'd0, id_scan_out}, 64'd0);
        chk("rmid_data", {32'd0, slave_data}, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("rmid_ready_after", {63'd0, master_ready}, 64'd1);
        tag          = 4'd0;
        slave_ready  = 8'hFF;
        master_data  = 32'hCAFEF00D;
        master_valid = 1'b1;
        step();
        master_valid = 1'b0;
        chk("rmid_ids_zero", {56'd0, slave_valid}, 64'hFF);
        step();
        chk("rmid_idle", {56'd0, slave_valid}, 64'd0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
